sonic_blocksync_param: RTL

Parametrised successor of the 10G block-lock FSM. Buffers the gearbox word stream, aligns it with a barrel shifter and runs the Clause 49 block-lock algorithm with configurable window, invalid threshold and post-slip hold. Outputs an aligned block stream with per-block header-error flags and lock statistics. Sits between the RX gearbox and the descrambler/decoder.

---
 rtl/sonic_blocksync_pkg.sv | 24 ++
 rtl/sonic_bit_aligner.sv | 49 ++++
 rtl/sonic_blocksync_param.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/sonic_blocksync_pkg.sv
// Shared types and constants for the parametrised block-lock datapath.
// Holds the lock FSM state encoding, default sizing and the sync-header check.
package sonic_blocksync_pkg;

    typedef enum logic [1:0] {
        ST_INIT      = 2'd0,
        ST_TEST_SH   = 2'd1,
        ST_SLIP_HOLD = 2'd2
    } blocksync_state_t;

    localparam int DEF_BLOCK_W     = 66;
    localparam int DEF_SH_WINDOW   = 64;
    localparam int DEF_INVALID_MAX = 16;
    localparam int DEF_SLIP_HOLD   = 1;

    localparam int SH_CNT_W   = 10;
    localparam int HOLD_CNT_W = 4;

    // A sync header is legal only when its two bits differ (01 or 10).
    function automatic logic sh_valid(input logic [1:0] sh);
        return sh[0] ^ sh[1];
    endfunction

endpackage

// File: rtl/sonic_bit_aligner.sv
// Two-word raw buffer plus barrel shifter; emits one aligned block per
// captured word once two words are held, selected by the current offset.
module sonic_bit_aligner
    import sonic_blocksync_pkg::*;
#(
    parameter int BLOCK_W = DEF_BLOCK_W
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [BLOCK_W-1:0]           in_data,
    input  logic                         in_valid,
    input  logic [$clog2(BLOCK_W)-1:0]   offset,
    output logic [BLOCK_W-1:0]           aligned,
    output logic                         eval
);

    logic [BLOCK_W-1:0]   rx_b1_reg;
    logic [BLOCK_W-1:0]   rx_b2_reg;
    logic                 new_blk_reg;
    logic                 have_one_reg;
    logic                 primed_reg;
    logic [2*BLOCK_W-1:0] combined;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_b1_reg    <= '0;
            rx_b2_reg    <= '0;
            new_blk_reg  <= 1'b0;
            have_one_reg <= 1'b0;
            primed_reg   <= 1'b0;
        end else begin
            new_blk_reg <= in_valid;
            if (in_valid) begin
                rx_b1_reg    <= in_data;
                rx_b2_reg    <= rx_b1_reg;
                have_one_reg <= 1'b1;
                if (have_one_reg) begin
                    primed_reg <= 1'b1;
                end
            end
        end
    end

    // Older word sits in the low half so bit order follows transmission order.
    assign combined = {rx_b1_reg, rx_b2_reg};
    assign aligned  = BLOCK_W'(combined >> offset);
    assign eval     = new_blk_reg && primed_reg;

endmodule

// File: rtl/sonic_blocksync_param.sv
// Block-lock FSM with configurable test window, invalid threshold and
// post-slip hold; registers the aligned block stream and lock statistics.
module sonic_blocksync_param
    import sonic_blocksync_pkg::*;
#(
    parameter int BLOCK_W     = DEF_BLOCK_W,
    parameter int SH_WINDOW   = DEF_SH_WINDOW,
    parameter int INVALID_MAX = DEF_INVALID_MAX,
    parameter int SLIP_HOLD   = DEF_SLIP_HOLD
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic [BLOCK_W-1:0]           in_data,
    input  logic                         in_valid,
    output logic [BLOCK_W-1:0]           out_data,
    output logic                         out_valid,
    output logic                         out_sh_err,
    output logic                         block_lock,
    output logic [$clog2(BLOCK_W)-1:0]   offset,
    output logic                         slip,
    output logic [15:0]                  slip_cnt
);

    localparam int OFF_W = $clog2(BLOCK_W);

    blocksync_state_t      state_reg, state_next;
    logic                  block_lock_reg, block_lock_next;
    logic [OFF_W-1:0]      offset_reg, offset_next;
    logic [SH_CNT_W-1:0]   sh_cnt_reg, sh_cnt_next, sh_cnt_inc;
    logic [SH_CNT_W-1:0]   sh_inv_reg, sh_inv_next, sh_inv_inc;
    logic [HOLD_CNT_W-1:0] hold_cnt_reg, hold_cnt_next, hold_cnt_inc;
    logic                  slip_reg, slip_next;
    logic [15:0]           slip_cnt_reg, slip_cnt_next;
    logic [BLOCK_W-1:0]    out_data_reg;
    logic                  out_valid_reg;
    logic                  out_sh_err_reg;
    logic                  enter_slip;
    logic [BLOCK_W-1:0]    aligned;
    logic                  eval;

    sonic_bit_aligner #(
        .BLOCK_W (BLOCK_W)
    ) u_aligner (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_data  (in_data),
        .in_valid (in_valid),
        .offset   (offset_reg),
        .aligned  (aligned),
        .eval     (eval)
    );

    assign sh_cnt_inc   = sh_cnt_reg + 1'b1;
    assign sh_inv_inc   = sh_inv_reg + 1'b1;
    assign hold_cnt_inc = hold_cnt_reg + 1'b1;

    always_comb begin
        state_next      = state_reg;
        block_lock_next = block_lock_reg;
        offset_next     = offset_reg;
        sh_cnt_next     = sh_cnt_reg;
        sh_inv_next     = sh_inv_reg;
        hold_cnt_next   = hold_cnt_reg;
        slip_next       = 1'b0;
        slip_cnt_next   = slip_cnt_reg;
        enter_slip      = 1'b0;

        case (state_reg)
            ST_INIT: begin
                block_lock_next = 1'b0;
                offset_next     = '0;
                sh_cnt_next     = '0;
                sh_inv_next     = '0;
                hold_cnt_next   = '0;
                state_next      = ST_TEST_SH;
            end
            ST_TEST_SH: begin
                if (eval) begin
                    if (sh_valid(aligned[1:0])) begin
                        if (sh_cnt_inc == SH_CNT_W'(SH_WINDOW)) begin
                            if (sh_inv_reg == '0) begin
                                block_lock_next = 1'b1;
                            end
                            sh_cnt_next = '0;
                            sh_inv_next = '0;
                        end else begin
                            sh_cnt_next = sh_cnt_inc;
                        end
                    end else if (!block_lock_reg || sh_inv_inc == SH_CNT_W'(INVALID_MAX)) begin
                        // Threshold wins over a coincident window end.
                        enter_slip = 1'b1;
                    end else if (sh_cnt_inc == SH_CNT_W'(SH_WINDOW)) begin
                        sh_cnt_next = '0;
                        sh_inv_next = '0;
                    end else begin
                        sh_cnt_next = sh_cnt_inc;
                        sh_inv_next = sh_inv_inc;
                    end
                end
            end
            ST_SLIP_HOLD: begin
                if (SLIP_HOLD == 0) begin
                    state_next = ST_TEST_SH;
                end else if (eval) begin
                    if (hold_cnt_inc == HOLD_CNT_W'(SLIP_HOLD)) begin
                        hold_cnt_next = '0;
                        state_next    = ST_TEST_SH;
                    end else begin
                        hold_cnt_next = hold_cnt_inc;
                    end
                end
            end
            default: begin
                state_next = ST_INIT;
            end
        endcase

        if (enter_slip) begin
            state_next      = ST_SLIP_HOLD;
            block_lock_next = 1'b0;
            sh_cnt_next     = '0;
            sh_inv_next     = '0;
            hold_cnt_next   = '0;
            slip_next       = 1'b1;
            if (slip_cnt_reg != 16'hFFFF) begin
                slip_cnt_next = slip_cnt_reg + 16'd1;
            end
            if (offset_reg == OFF_W'(BLOCK_W - 1)) begin
                offset_next = '0;
            end else begin
                offset_next = offset_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= ST_INIT;
            block_lock_reg <= 1'b0;
            offset_reg     <= '0;
            sh_cnt_reg     <= '0;
            sh_inv_reg     <= '0;
            hold_cnt_reg   <= '0;
            slip_reg       <= 1'b0;
            slip_cnt_reg   <= '0;
            out_data_reg   <= '0;
            out_valid_reg  <= 1'b0;
            out_sh_err_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            block_lock_reg <= block_lock_next;
            offset_reg     <= offset_next;
            sh_cnt_reg     <= sh_cnt_next;
            sh_inv_reg     <= sh_inv_next;
            hold_cnt_reg   <= hold_cnt_next;
            slip_reg       <= slip_next;
            slip_cnt_reg   <= slip_cnt_next;
            out_valid_reg  <= eval;
            if (eval) begin
                out_data_reg   <= aligned;
                out_sh_err_reg <= !sh_valid(aligned[1:0]);
            end
        end
    end

    assign out_data   = out_data_reg;
    assign out_valid  = out_valid_reg;
    assign out_sh_err = out_sh_err_reg;
    assign block_lock = block_lock_reg;
    assign offset     = offset_reg;
    assign slip       = slip_reg;
    assign slip_cnt   = slip_cnt_reg;

endmodule
